// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU front end.
// Contents:
//   CPU_XLEN      default address / PC width in bits
//   CPU_INST_W    default instruction word width in bits
//   CPU_PC_STEP   sequential PC increment in bytes
//   fetch_state_t fetch stage state encoding {IDLE, REQ, DRAIN, HOLD}
package cpu_pkg;

  localparam int CPU_XLEN    = 32;
  localparam int CPU_INST_W  = 32;
  localparam int CPU_PC_STEP = 4;

  // IDLE  : one quiet cycle after reset release
  // REQ   : memory read outstanding, result will be kept
  // DRAIN : memory read outstanding, result will be thrown away (redirected)
  // HOLD  : instruction buffered and offered to decode
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage that sits right after the PC register. It reads
// the instruction at the current PC over a req/ack memory port, parks the
// word in a one-entry buffer for decode (valid/ready), and tells the PC
// register what to load next: the sequential address or a redirect target.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous, active-high reset
//   pc_in            current PC (PC register output)
//   pc_next          value for the PC register to load
//   pc_en            PC load enable, single-cycle pulse
//   imem_req         instruction memory read request
//   imem_addr        instruction memory read address (= pc_in)
//   imem_ack         read data valid this cycle
//   imem_rdata       read data
//   redirect_valid   branch/jump redirect pulse
//   redirect_target  redirect PC
//   inst_valid       buffered instruction valid to decode
//   inst_ready       decode accepts the instruction
//   inst_out         buffered instruction
//   inst_pc          PC of the buffered instruction
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int XLEN    = CPU_XLEN,
  parameter int INST_W  = CPU_INST_W,
  parameter int PC_STEP = CPU_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_in,
  output logic [XLEN-1:0]   pc_next,
  output logic              pc_en,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   inst_pc
);

  fetch_state_t    state;
  logic [XLEN-1:0] pend_tgt;
  logic [XLEN-1:0] seq_pc;

  // The PC only moves when we pulse pc_en, so pc_in is stable for the whole
  // life of a request and can drive the memory address directly.
  assign imem_addr = pc_in;

  // Sequential successor; wraps naturally at 2^XLEN.
  assign seq_pc = pc_in + XLEN'(PC_STEP);

  // Next-PC selection. The PC is only ever loaded on a memory ack (end of a
  // fetch) or when a redirect lands while an instruction is buffered.
  // A redirect that arrives while a read is outstanding cannot load the PC
  // yet, since the address must stay stable; it is parked in pend_tgt and
  // applied when the stale read finally acks. A redirect on the ack cycle
  // itself is fresher than anything parked, so it takes priority.
  always_comb begin
    pc_en   = 1'b0;
    pc_next = '0;
    unique case (state)
      REQ: begin
        if (imem_ack) begin
          pc_en   = 1'b1;
          pc_next = redirect_valid ? redirect_target : seq_pc;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          pc_en   = 1'b1;
          pc_next = redirect_valid ? redirect_target : pend_tgt;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_en   = 1'b1;
          pc_next = redirect_target;
        end
      end
      default: begin
        pc_en   = 1'b0;
        pc_next = '0;
      end
    endcase
  end

  // Fetch controller. imem_req and inst_valid are registered alongside the
  // state so that they are exactly "state is REQ/DRAIN" and "state is HOLD".
  // Once imem_req rises it only falls on the ack that completes the read,
  // so a request is never withdrawn. Redirects always beat both sequential
  // advance and the decode handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
      pend_tgt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (imem_ack && !redirect_valid) begin
            inst_out   <= imem_rdata;
            inst_pc    <= pc_in;
            state      <= HOLD;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end else if (!imem_ack && redirect_valid) begin
            pend_tgt <= redirect_target;
            state    <= DRAIN;
          end
          // ack together with redirect: data dropped, PC reloaded, and the
          // request simply continues at the new address.
        end

        DRAIN: begin
          if (redirect_valid) begin
            pend_tgt <= redirect_target;
          end
          if (imem_ack) begin
            state <= REQ;
          end
        end

        HOLD: begin
          // Either a completed handshake or a redirect frees the buffer.
          // On a handshake the PC was already advanced on entry to HOLD.
          if (redirect_valid || inst_ready) begin
            state      <= REQ;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. The bench plays the PC register and
// the instruction memory, and keeps a transaction-level reference model of
// the fetch stage (request outstanding / result squashed / buffer full).
module tb_fetch_unit;

  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   pc_next;
  logic              pc_en;
  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_target;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [XLEN-1:0]   inst_pc;

  int tests    = 0;
  int failures = 0;

  // Reference model state
  bit              m_warm;
  bit              m_busy;
  bit              m_squash;
  bit              m_full;
  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] m_pend;
  logic [INST_W-1:0] m_buf;
  logic [XLEN-1:0] m_buf_pc;
  logic            m_en;
  logic [XLEN-1:0] m_next;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN    (XLEN),
    .INST_W  (INST_W),
    .PC_STEP (PC_STEP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_next         (pc_next),
    .pc_en           (pc_en),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_warm   = 1'b0;
    m_busy   = 1'b0;
    m_squash = 1'b0;
    m_full   = 1'b0;
    m_pc     = '0;
    m_pend   = '0;
    m_buf    = '0;
    m_buf_pc = '0;
    m_en     = 1'b0;
    m_next   = '0;
  endtask

  // What the PC register should be told this cycle.
  task automatic model_outputs();
    m_en   = 1'b0;
    m_next = '0;
    if (m_busy && imem_ack) begin
      m_en = 1'b1;
      if (redirect_valid)  m_next = redirect_target;
      else if (m_squash)   m_next = m_pend;
      else                 m_next = m_pc + 32'(PC_STEP);
    end else if (m_full && redirect_valid) begin
      m_en   = 1'b1;
      m_next = redirect_target;
    end
  endtask

  // Effect of one rising clock edge on the model.
  task automatic model_advance();
    if (m_warm) begin
      m_warm = 1'b0;
      m_busy = 1'b1;
    end else if (m_busy) begin
      if (imem_ack) begin
        if (!m_squash && !redirect_valid) begin
          m_full   = 1'b1;
          m_busy   = 1'b0;
          m_buf    = imem_rdata;
          m_buf_pc = m_pc;
        end
        m_squash = 1'b0;
      end else if (redirect_valid) begin
        m_squash = 1'b1;
        m_pend   = redirect_target;
      end
    end else if (m_full) begin
      if (redirect_valid || inst_ready) begin
        m_full = 1'b0;
        m_busy = 1'b1;
      end
    end
    if (m_en) m_pc = m_next;
  endtask

  // Drive one cycle's inputs at the falling edge, let outputs settle.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic rv, input logic [31:0] tgt,
                               input logic ready);
    @(negedge clk);
    imem_ack        = ack;
    imem_rdata      = rdata;
    redirect_valid  = rv;
    redirect_target = tgt;
    inst_ready      = ready;
    #1;
    model_outputs();
  endtask

  task automatic checkOutput();
    chk("imem_req",   32'(imem_req),   32'(m_busy));
    chk("imem_addr",  imem_addr,       m_pc);
    chk("pc_en",      32'(pc_en),      32'(m_en));
    chk("pc_next",    pc_next,         m_next);
    chk("inst_valid", 32'(inst_valid), 32'(m_full));
    chk("inst_out",   inst_out,        m_buf);
    chk("inst_pc",    inst_pc,         m_buf_pc);
  endtask

  // Rising edge: PC register loads from the model's prediction.
  task automatic clockEdge();
    @(posedge clk);
    model_advance();
    #1;
    pc_in = m_pc;
  endtask

  task automatic cycle(input logic ack, input logic [31:0] rdata,
                       input logic rv, input logic [31:0] tgt, input logic ready);
    applyStimulus(ack, rdata, rv, tgt, ready);
    checkOutput();
    clockEdge();
  endtask

  initial begin
    rst             = 1'b1;
    pc_in           = '0;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput();
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc_en", 32'(pc_en),      32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_warm = 1'b1;

    // 1: IDLE cycle, then same-cycle ack at PC 0
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t1_idle_req", 32'(imem_req), 32'd0);
    clockEdge();
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t1_pc_en",   32'(pc_en), 32'd1);
    chk("t1_pc_next", pc_next,    32'h4);
    clockEdge();

    // 2: HOLD with ready low for 3 cycles, then accept
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput();
      chk("t2_valid",   32'(inst_valid), 32'd1);
      chk("t2_inst",    inst_out,        32'hDEADBEEF);
      chk("t2_inst_pc", inst_pc,         32'h0);
      chk("t2_req",     32'(imem_req),   32'd0);
      clockEdge();
    end
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // REQ at 4: ack with redirect to 0x100 drops the data
    applyStimulus(1'b1, 32'h55555555, 1'b1, 32'h100, 1'b0);
    checkOutput();
    chk("t2_addr",      imem_addr, 32'h4);
    chk("t3_rd_pcnext", pc_next,   32'h100);
    clockEdge();

    // 3: REQ at 0x100, redirect to 0x200 before a late ack
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    checkOutput();
    chk("t3_addr", imem_addr, 32'h100);
    clockEdge();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      checkOutput();
      chk("t3_drain_valid", 32'(inst_valid), 32'd0);
      chk("t3_drain_req",   32'(imem_req),   32'd1);
      clockEdge();
    end
    applyStimulus(1'b1, 32'h11111111, 1'b0, 32'h0, 1'b1);
    checkOutput();
    chk("t3_pc_en",   32'(pc_en), 32'd1);
    chk("t3_pc_next", pc_next,    32'h200);
    clockEdge();
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t3_no_valid", 32'(inst_valid), 32'd0);
    chk("t3_addr2",    imem_addr,       32'h200);
    clockEdge();

    // 4: redirect beats ready in HOLD
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
    checkOutput();
    chk("t4_inst",    inst_out, 32'hCAFEF00D);
    chk("t4_pc_next", pc_next,  32'h400);
    clockEdge();
    applyStimulus(1'b1, 32'h0BADC0DE, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t4_valid", 32'(inst_valid), 32'd0);
    chk("t4_addr",  imem_addr,       32'h400);
    clockEdge();

    // 5: wrap at top of address space
    cycle(1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 1'b0);
    applyStimulus(1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t5_addr",    imem_addr, 32'hFFFFFFFC);
    chk("t5_pc_next", pc_next,   32'h0);
    clockEdge();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // 6: async reset in the middle of a request
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t6_pre_req", 32'(imem_req), 32'd1);
    #2;
    rst   = 1'b1;
    pc_in = '0;
    model_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'hA5A5A5A5;
    #1;
    checkOutput();
    chk("t6_rst_req",   32'(imem_req),   32'd0);
    chk("t6_rst_valid", 32'(inst_valid), 32'd0);
    chk("t6_rst_inst",  inst_out,        32'h0);
    chk("t6_rst_pc_en", 32'(pc_en),      32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_warm = 1'b1;
    applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t6_idle_req",   32'(imem_req), 32'd0);
    chk("t6_idle_pc_en", 32'(pc_en),    32'd0);
    clockEdge();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput();
    chk("t6_first_req", 32'(imem_req), 32'd1);
    clockEdge();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)),
            $urandom,
            ($urandom_range(0, 99) < 15),
            $urandom & 32'hFFFFFFFC,
            1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly downstream of the program counter register.
- Consumes the PC's current value, issues a req/ack read to instruction memory, and holds the fetched word in a one-entry buffer for decode (valid/ready).
- Drives the PC's data/enable inputs: sequential PC+PC_STEP, or a redirect target from branch/jump resolution.

Parameters:
XLEN, 32, address/PC width
INST_W, 32, instruction word width
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pc_in  in  XLEN  current PC (PC register output)
pc_next  out  XLEN  value to load into PC
pc_en  out  1  PC load enable; PC updates on next clk edge
imem_req  out  1  instruction memory read request
imem_addr  out  XLEN  read address
imem_ack  in  1  read data valid this cycle
imem_rdata  in  INST_W  read data
redirect_valid  in  1  branch/jump redirect, single-cycle pulse
redirect_target  in  XLEN  redirect PC
inst_valid  out  1  held instruction valid to decode
inst_ready  in  1  decode accepts instruction
inst_out  out  INST_W  held instruction
inst_pc  out  XLEN  PC of held instruction

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - inst_out=0, inst_pc=0, inst_valid=0.
  - imem_req=0, pc_en=0, pc_next=0, pend_tgt=0.
- imem_addr = pc_in combinationally. It is stable while imem_req=1 because the PC only updates through pc_en.
- Memory protocol:
  - imem_req is held high until imem_ack.
  - Once issued, a request is never withdrawn.
  - imem_ack is ignored when imem_req=0.
- pc_en and pc_next are combinational outputs of the state and inputs. pc_en is a single-cycle pulse.
- States:
  - IDLE: outputs idle; goes to REQ next cycle. Applies to the first cycle after reset release only.
  - REQ: imem_req=1.
    - ack & !redirect_valid: capture inst_out=imem_rdata, inst_pc=pc_in; pc_en=1, pc_next=pc_in+PC_STEP; -> HOLD.
    - ack & redirect_valid: discard data; pc_en=1, pc_next=redirect_target; -> REQ.
    - !ack & redirect_valid: latch pend_tgt=redirect_target; -> DRAIN.
    - otherwise: stay in REQ.
  - DRAIN: imem_req=1; in-flight fetch is to be discarded; inst_valid=0.
    - redirect_valid (any ack): pend_tgt overwritten; the newest target wins.
    - ack: discard data; pc_en=1, pc_next = redirect_valid ? redirect_target : pend_tgt; -> REQ.
  - HOLD: inst_valid=1, imem_req=0.
    - redirect_valid: drop the instruction (the handshake does not complete even if inst_ready=1); pc_en=1, pc_next=redirect_target; -> REQ.
    - inst_ready & !redirect_valid: transfer complete; -> REQ. The PC already advanced on entry, so pc_in is the new address.
    - otherwise: hold inst_out/inst_pc stable.
- Latency and throughput:
  - The ack cycle is followed by inst_valid on the next cycle.
  - Peak rate is 1 instruction per 2 cycles (REQ with same-cycle ack, then HOLD with ready).
- Arithmetic: pc_in+PC_STEP is modulo 2^XLEN; 0xFFFFFFFC wraps to 0x00000000. No alignment checking.
- Redirect priority: redirect beats the inst_ready handshake and beats sequential advance.
- Reset mid-operation: state returns to IDLE immediately and inst_valid drops. A pending memory ack after reset is ignored, since it arrives in IDLE where imem_req=0.

Decomposition:
- Shared package (cpu_pkg):
  - fetch state enum {IDLE, REQ, DRAIN, HOLD}
  - XLEN/INST_W defaults
  - PC_STEP constant
- No sub-module. The incrementer and next-PC mux are inline. A standalone next_pc_mux is not warranted.

Test Plan:
1. Reset release with pc_in=0x00000000, ack same cycle with rdata=0xDEADBEEF -> pc_en=1, pc_next=0x00000004; next cycle inst_valid=1, inst_out=0xDEADBEEF, inst_pc=0x00000000.
2. HOLD with inst_ready=0 for 3 cycles -> inst_out/inst_pc stable, imem_req=0, pc_en=0. ready=1 -> next cycle REQ with imem_addr=0x00000004.
3. REQ at pc=0x100, ack delayed 3 cycles, redirect_valid pulse with target 0x200 in cycle 1 -> DRAIN, inst_valid never asserts for 0x100 data. On ack: pc_en=1, pc_next=0x200.
4. HOLD with inst_valid=1, inst_ready=1 and redirect_valid=1 (target 0x400) same cycle -> no transfer counted, pc_next=0x400, next state REQ.
5. pc_in=0xFFFFFFFC, ack -> pc_next=0x00000000.
6. rst asserted asynchronously mid-REQ, ack arrives during reset and in the first post-reset cycle -> all outputs 0, ack ignored, first request issued in the second cycle after release.
